// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with a two-entry skid buffer,
// synchronous flush and a saturating stall counter for performance debug.
module pipe_stage_skid #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 2,
    parameter int CNT_W      = 16
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W*NUM_FIELDS-1:0] in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W*NUM_FIELDS-1:0] out_data,
    output logic [1:0]                   occupancy,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int W = DATA_W * NUM_FIELDS;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [W-1:0]     main_r, main_nxt_s;
    logic [W-1:0]     skid_r, skid_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             acc_s, take_s;

    // State and payload registers
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= ST_EMPTY;
            main_r  <= {W{1'b0}};
            skid_r  <= {W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            main_r  <= main_nxt_s;
            skid_r  <= skid_nxt_s;
        end
    end

    // Next-state and payload steering; flush overrides any accept
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = {W{1'b0}};
            skid_nxt_s  = {W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = in_data;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && !take_s) begin
                        state_nxt_s = ST_FULL;
                        skid_nxt_s  = in_data;
                    end else if (acc_s && take_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = in_data;
                    end else if (take_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (take_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = skid_r;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    main_nxt_s  = {W{1'b0}};
                    skid_nxt_s  = {W{1'b0}};
                end
            endcase
        end
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        out_valid = (state_r != ST_EMPTY);
        in_ready  = (state_r != ST_FULL);
        occupancy = state_r;
        out_data  = main_r;
        stall_cnt = stall_cnt_r;
        acc_s     = in_valid & in_ready;
        take_s    = out_valid & out_ready;
    end

    // Saturating stall counter; only clear resets it
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r != ST_EMPTY) && !out_ready && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule
